// File: rtl/axi_unpack_pkg.sv
// Shared definitions for the flat-word stream unpacker and its packers.
// Flat word layout, LSB first: err, eop, sop, mod, dat, ctl.
package axi_unpack_pkg;

   typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} unpack_state_t;

   localparam int ERR_CNT_BITS = 16;

   localparam int ERR_POS = 0;
   localparam int EOP_POS = 1;
   localparam int SOP_POS = 2;
   localparam int MOD_LSB = 3;

   function automatic int flat_bits(input int dat, input int mod, input int ctl);
      return ctl + dat + mod + 3;
   endfunction

   function automatic int dat_lsb(input int mod);
      return MOD_LSB + mod;
   endfunction

   function automatic int ctl_lsb(input int dat, input int mod);
      return MOD_LSB + mod + dat;
   endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Stream interface carried between blocks: val/rdy handshake plus payload.
interface if_axi_stream #(
   parameter int DAT_BITS = 64,
   parameter int MOD_BITS = 3,
   parameter int CTL_BITS = 8
);
   logic                val;
   logic                rdy;
   logic [DAT_BITS-1:0] dat;
   logic [MOD_BITS-1:0] mod;
   logic [CTL_BITS-1:0] ctl;
   logic                sop;
   logic                eop;
   logic                err;

   modport source (output val, dat, mod, ctl, sop, eop, err, input rdy);
   modport sink   (input  val, dat, mod, ctl, sop, eop, err, output rdy);
endinterface

// File: rtl/axi_stream_skid.sv
// Generic 2-entry in-order skid buffer. Outputs come straight from flops;
// the upstream ready is registered and never looks at the downstream ready.
module axi_stream_skid #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_val,
   input  logic [W-1:0] i_dat,
   output logic         o_rdy,
   output logic         o_val,
   input  logic         i_rdy,
   output logic [W-1:0] o_dat
);
   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] ent0_q, ent1_q;
   logic         rdy_q;
   logic         push, pop, wr_head;

   assign push    = i_val && rdy_q;
   assign pop     = (cnt_q != 2'd0) && i_rdy;
   assign cnt_d   = cnt_q + 2'(push) - 2'(pop);
   // A pushed word lands in the head slot when the head is free this cycle.
   assign wr_head = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop);

   // Occupancy, storage and registered ready.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q  <= 2'd0;
         rdy_q  <= 1'b0;
         ent0_q <= '0;
         ent1_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         rdy_q <= (cnt_d < 2'd2);
         if (push && wr_head)
            ent0_q <= i_dat;
         else if (pop)
            ent0_q <= ent1_q;
         if (push && !wr_head)
            ent1_q <= i_dat;
      end
   end

   assign o_rdy = rdy_q;
   assign o_val = (cnt_q != 2'd0);
   assign o_dat = ent0_q;

endmodule

// File: rtl/axi_stream_unpack_rd.sv
// Read-side unpacker: flat FIFO words -> stream source, with sop/eop framing
// checks. Optional build macro AXI_UNPACK_DROP_ORPHAN_EN discards words that
// arrive outside a packet instead of forwarding them flagged.
module axi_stream_unpack_rd
   import axi_unpack_pkg::*;
#(
   parameter int DAT_BITS  = 64,
   parameter int MOD_BITS  = 3,
   parameter int CTL_BITS  = 8,
   parameter int FLAT_BITS = flat_bits(DAT_BITS, MOD_BITS, CTL_BITS)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_val,
   input  logic [FLAT_BITS-1:0]    i_dat,
   output logic                    o_rdy,
   if_axi_stream.source            o_axi,
   output logic [ERR_CNT_BITS-1:0] o_err_cnt,
   output logic                    o_in_pkt
);
   localparam int DAT_LSB = dat_lsb(MOD_BITS);
   localparam int CTL_LSB = ctl_lsb(DAT_BITS, MOD_BITS);

   unpack_state_t          state_q, state_d;
   logic                   acc, in_sop, in_eop;
   logic                   is_orphan, viol_word, drop;
   logic                   sk_val;
   logic [FLAT_BITS-1:0]   fwd_dat, sk_dat;
   logic [ERR_CNT_BITS-1:0] err_cnt_q;

   assign acc       = i_val && o_rdy;
   assign in_sop    = i_dat[SOP_POS];
   assign in_eop    = i_dat[EOP_POS];
   assign is_orphan = !in_sop && (state_q == IDLE);
   // sop inside a packet means the previous packet lost its eop.
   assign viol_word = in_sop ? (state_q == IN_PKT) : is_orphan;
   assign fwd_dat   = {i_dat[FLAT_BITS-1:1], i_dat[ERR_POS] | viol_word};

`ifdef AXI_UNPACK_DROP_ORPHAN_EN
   assign drop = is_orphan;
`else
   assign drop = 1'b0;
`endif

   // Framing next state; a sop always restarts framing from that word's eop.
   always_comb begin
      state_d = state_q;
      if (acc) begin
         if (in_sop)
            state_d = in_eop ? IDLE : IN_PKT;
         else if (state_q == IN_PKT)
            state_d = in_eop ? IDLE : IN_PKT;
         else
            state_d = IDLE;
      end
   end

   // Framing state and saturating violation counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (acc && viol_word && (err_cnt_q != '1))
            err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   axi_stream_skid #(.W(FLAT_BITS)) u_skid (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_val   (i_val && !drop),
      .i_dat   (fwd_dat),
      .o_rdy   (o_rdy),
      .o_val   (sk_val),
      .i_rdy   (o_axi.rdy),
      .o_dat   (sk_dat)
   );

   assign o_axi.val = sk_val;
   assign o_axi.err = sk_dat[ERR_POS];
   assign o_axi.eop = sk_dat[EOP_POS];
   assign o_axi.sop = sk_dat[SOP_POS];
   assign o_axi.mod = sk_dat[DAT_LSB-1:MOD_LSB];
   assign o_axi.dat = sk_dat[CTL_LSB-1:DAT_LSB];
   assign o_axi.ctl = sk_dat[FLAT_BITS-1:CTL_LSB];

   assign o_err_cnt = err_cnt_q;
   assign o_in_pkt  = (state_q == IN_PKT);

endmodule

// File: tb/tb_axi_stream_unpack_rd.sv
// Bench for axi_stream_unpack_rd: directed table, hand sequences for
// backpressure and reset, then randomized traffic against a queue model.
module tb_axi_stream_unpack_rd;
   localparam int DB = 64, MB = 3, CB = 8, FB = CB + DB + MB + 3;
`ifdef AXI_UNPACK_DROP_ORPHAN_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic          clk = 1'b0, rst_n = 1'b1, i_val = 1'b0;
   logic [FB-1:0] i_dat = '0;
   logic          o_rdy, o_in_pkt;
   logic [15:0]   o_err_cnt;

   if_axi_stream #(.DAT_BITS(DB), .MOD_BITS(MB), .CTL_BITS(CB)) axi ();

   axi_stream_unpack_rd dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_val     (i_val),
      .i_dat     (i_dat),
      .o_rdy     (o_rdy),
      .o_axi     (axi),
      .o_err_cnt (o_err_cnt),
      .o_in_pkt  (o_in_pkt)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   // Reference model: words expected on the output, framing flag, violations.
   logic [FB-1:0] q[$];
   bit            m_in_pkt = 1'b0;
   int            m_cnt = 0;

   typedef struct {
      bit          val;
      bit          s, e, r;
      logic [63:0] d;
      bit          exp_in_pkt;
      int          exp_cnt;
   } vec_t;
   vec_t tbl[13];

   function automatic logic [FB-1:0] mk(logic [7:0] c, logic [63:0] d, logic [2:0] m,
                                         bit s, bit e, bit r);
      return {c, d, m, s, e, r};
   endfunction

   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, a, e);
      end
   endtask

   task automatic model_accept(input logic [FB-1:0] w);
      bit s, e, viol, orphan;
      s = w[2];
      e = w[1];
      viol   = s ? m_in_pkt : !m_in_pkt;
      orphan = !s && !m_in_pkt;
      if (viol && m_cnt < 65535) m_cnt++;
      if (!(DROP && orphan)) q.push_back({w[FB-1:1], w[0] | viol});
      m_in_pkt = s ? !e : (m_in_pkt && !e);
   endtask

   // One clock: observe handshakes, update model, then check registered outputs.
   task automatic step(output bit acc);
      bit pop;
      logic [FB-1:0] act;
      acc = i_val && o_rdy;
      pop = axi.val && axi.rdy;
      if (pop) begin
         act = {axi.ctl, axi.dat, axi.mod, axi.sop, axi.eop, axi.err};
         chk("pop_has_expected", 128'(q.size() != 0), 128'd1);
         if (q.size() != 0) begin
            chk("beat", 128'(act), 128'(q[0]));
            void'(q.pop_front());
         end
      end
      if (acc) model_accept(i_dat);
      @(posedge clk);
      #1;
      chk("o_rdy", 128'(o_rdy), 128'(q.size() < 2));
      chk("o_axi_val", 128'(axi.val), 128'(q.size() != 0));
      chk("err_cnt", 128'(o_err_cnt), 128'(m_cnt));
      chk("in_pkt", 128'(o_in_pkt), 128'(m_in_pkt));
   endtask

   initial begin
      bit acc, ok;
      tbl[0]  = '{1, 1, 0, 0, 64'h1,  1, 0};
      tbl[1]  = '{1, 0, 0, 0, 64'h2,  1, 0};
      tbl[2]  = '{1, 0, 1, 0, 64'h3,  0, 0};
      tbl[3]  = '{0, 0, 0, 0, 64'h0,  0, 0};
      tbl[4]  = '{1, 0, 0, 0, 64'hAA, 0, 1};
      tbl[5]  = '{0, 0, 0, 0, 64'h0,  0, 1};
      tbl[6]  = '{1, 1, 0, 0, 64'h5,  1, 1};
      tbl[7]  = '{1, 1, 1, 0, 64'h6,  0, 2};
      tbl[8]  = '{0, 0, 0, 0, 64'h0,  0, 2};
      tbl[9]  = '{1, 1, 1, 1, 64'h7,  0, 2};
      tbl[10] = '{0, 0, 0, 0, 64'h0,  0, 2};
      tbl[11] = '{1, 1, 0, 0, 64'h8,  1, 2};
      tbl[12] = '{1, 0, 1, 1, 64'h9,  0, 2};

      axi.rdy = 1'b0;
      #1 rst_n = 1'b0;
      #11;
      chk("rst_rdy", 128'(o_rdy), 128'd0);
      chk("rst_val", 128'(axi.val), 128'd0);
      chk("rst_dat", 128'(axi.dat), 128'd0);
      chk("rst_cnt", 128'(o_err_cnt), 128'd0);
      chk("rst_in_pkt", 128'(o_in_pkt), 128'd0);
      rst_n = 1'b1;
      #1 chk("rel_rdy_low", 128'(o_rdy), 128'd0);
      @(posedge clk);
      #1;
      chk("rel_rdy_cycle1", 128'(o_rdy), 128'd1);
      chk("rel_val", 128'(axi.val), 128'd0);

      // Directed table, output always ready.
      axi.rdy = 1'b1;
      foreach (tbl[k]) begin
         i_val = tbl[k].val;
         i_dat = mk(tbl[k].d[7:0] ^ 8'h5A, tbl[k].d, tbl[k].d[2:0],
                    tbl[k].s, tbl[k].e, tbl[k].r);
         step(acc);
         chk("tbl_in_pkt", 128'(o_in_pkt), 128'(tbl[k].exp_in_pkt));
         chk("tbl_err_cnt", 128'(o_err_cnt), 128'(tbl[k].exp_cnt));
      end
      i_val = 1'b0;
      repeat (2) step(acc);

      // Backpressure: 3-beat packet against a stalled sink.
      axi.rdy = 1'b0;
      i_val = 1'b1;
      i_dat = mk(8'h10, 64'd1, 3'd1, 1, 0, 0);
      step(acc);
      chk("bp_acc1", 128'(acc), 128'd1);
      i_dat = mk(8'h11, 64'd2, 3'd2, 0, 0, 0);
      step(acc);
      chk("bp_acc2", 128'(acc), 128'd1);
      i_dat = mk(8'h12, 64'd3, 3'd3, 0, 1, 0);
      repeat (3) begin
         step(acc);
         chk("bp_blocked", 128'(acc), 128'd0);
      end
      chk("bp_hold_dat", 128'(axi.dat), 128'd1);
      axi.rdy = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 10 && !ok; n++) begin
         step(acc);
         ok = acc;
      end
      chk("bp_third_accepted", 128'(ok), 128'd1);
      i_val = 1'b0;
      repeat (4) step(acc);
      chk("bp_drained", 128'(q.size()), 128'd0);

      // Reset while two words are buffered mid-packet.
      axi.rdy = 1'b0;
      i_val = 1'b1;
      i_dat = mk(8'h20, 64'h11, 3'd0, 1, 0, 0);
      step(acc);
      i_dat = mk(8'h21, 64'h12, 3'd0, 0, 0, 0);
      step(acc);
      i_val = 1'b0;
      chk("mid_in_pkt", 128'(o_in_pkt), 128'd1);
      chk("mid_buffered", 128'(q.size()), 128'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_val", 128'(axi.val), 128'd0);
      chk("arst_in_pkt", 128'(o_in_pkt), 128'd0);
      chk("arst_rdy", 128'(o_rdy), 128'd0);
      q.delete();
      m_in_pkt = 1'b0;
      m_cnt = 0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      axi.rdy = 1'b1;
      repeat (3) step(acc);
      i_val = 1'b1;
      i_dat = mk(8'h33, 64'h33, 3'd5, 1, 1, 0);
      step(acc);
      i_val = 1'b0;
      repeat (2) step(acc);

      // Randomized traffic; input word held until accepted.
      acc = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (!i_val || acc) begin
            i_val = ($urandom % 10) < 7;
            i_dat = mk(8'($urandom), {$urandom, $urandom}, 3'($urandom),
                       ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 8) == 0);
         end
         axi.rdy = ($urandom % 4) != 0;
         step(acc);
      end
      i_val = 1'b0;
      axi.rdy = 1'b1;
      repeat (4) step(acc);
      chk("final_drained", 128'(q.size()), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
